// File: rtl/cpu_sequencer.sv
// FETCH->EXEC->WB control unit for the 8-bit accumulator computer, with run/step/halt control.
// Optional JMP instruction (IR[8:4]==5'b10010) is enabled by defining CTRL_JUMP_EN.
module cpu_sequencer #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step_req,
    output logic               step_ack,
    input  logic               halt_req,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               load_a,
    output logic               load_b,
    output logic               mux_b_sel,
    output logic [1:0]         alu_sel,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t             state, state_d;
    logic [INSTR_W-1:0] ir, ir_d;
    logic [PC_W-1:0]    pc_d;
    logic [CNT_W-1:0]   retired_d;
    logic               step_flag, step_d;
    logic               hreq_flag, hreq_d;
    logic               is_halt, is_jmp;

    assign is_halt = (ir[8:4] == 5'b10011);
`ifdef CTRL_JUMP_EN
    assign is_jmp  = (ir[8:4] == 5'b10010);
`else
    logic unused_lit;
    assign is_jmp     = 1'b0;
    assign unused_lit = ^ir[3:0];
`endif

    // WB-side effects (pc, retired, loads, step_ack) are registered on the EXEC->WB edge
    // so they are visible for exactly the WB cycle.
    always_comb begin
        state_d   = state;
        ir_d      = ir;
        pc_d      = pc;
        retired_d = retired;
        step_d    = step_flag;
        hreq_d    = hreq_flag;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end else if (step_req) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                hreq_d  = hreq_flag | halt_req;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                hreq_d  = hreq_flag | halt_req;
                state_d = S_WB;
                if (is_jmp)
                    pc_d = PC_W'(ir[3:0]);
                else if (!is_halt)
                    pc_d = pc + PC_W'(1);
                if (retired != '1)
                    retired_d = retired + CNT_W'(1);
            end
            S_WB: begin
                step_d = 1'b0;
                hreq_d = 1'b0;
                if (is_halt)
                    state_d = S_HALT;
                else if (hreq_flag || halt_req || step_flag || !run)
                    state_d = S_IDLE;
                else
                    state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir        <= '0;
            pc        <= '0;
            retired   <= '0;
            step_flag <= 1'b0;
            hreq_flag <= 1'b0;
            load_a    <= 1'b0;
            load_b    <= 1'b0;
            step_ack  <= 1'b0;
            mux_b_sel <= 1'b0;
            alu_sel   <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_d;
            ir        <= ir_d;
            pc        <= pc_d;
            retired   <= retired_d;
            step_flag <= step_d;
            hreq_flag <= hreq_d;
            load_a    <= (state == S_EXEC) && ir[6] && !is_halt && !is_jmp;
            load_b    <= (state == S_EXEC) && ir[7] && !is_halt && !is_jmp;
            step_ack  <= (state == S_EXEC) && step_flag;
            mux_b_sel <= (state_d == S_EXEC || state_d == S_WB) && ir_d[8];
            alu_sel   <= (state_d == S_EXEC || state_d == S_WB) ? ir_d[5:4] : 2'b00;
            busy      <= (state_d == S_FETCH || state_d == S_EXEC || state_d == S_WB);
            halted    <= (state_d == S_HALT);
        end
    end

endmodule
